// File: rtl/spi_eeprom_slave.sv
`timescale 1ns/1ps
// SPI mode-0 responder emulating a small serial EEPROM (WREN/WRDI/RDSR/READ/WRITE).
// SCK, CSN and MOSI are oversampled on clk; all SPI timing follows the detected SCK edges.
module spi_eeprom_slave #(
  parameter int AW      = 7,
  parameter int PAGE_AW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic csn,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic wel
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    RD_DATA = 3'd3,
    WR_DATA = 3'd4,
    STATUS  = 3'd5,
    IGNORE  = 3'd6
  } state_t;

  localparam logic [1:0] WOP_NONE  = 2'd0;
  localparam logic [1:0] WOP_SET   = 2'd1;
  localparam logic [1:0] WOP_CLEAR = 2'd2;

  logic [2:0]    sck_q;
  logic [1:0]    csn_q;
  logic [1:0]    mosi_q;

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    shift_q;
  logic [7:0]    tx_q;
  logic [AW-1:0] addr_q;
  logic          rd_q;
  logic          miso_q;
  logic          miso_oe_q;
  logic          wel_q;
  logic [1:0]    wen_op_q;
  logic          extra_q;
  logic          wrote_q;
  logic          wr_pend_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    mem_q [0:(1<<AW)-1];

  logic          sck_rise;
  logic          sck_fall;
  logic          csn_s;
  logic          mosi_s;
  logic          last_bit;
  logic [7:0]    rx_byte;
  logic [7:0]    status_byte;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] addr_page_inc;

  assign sck_rise      = sck_q[1] & ~sck_q[2];
  assign sck_fall      = ~sck_q[1] & sck_q[2];
  assign csn_s         = csn_q[1];
  assign mosi_s        = mosi_q[1];
  assign last_bit      = (bit_cnt_q == 3'd7);
  assign rx_byte       = {shift_q, mosi_s};
  assign status_byte   = {6'b000000, wel_q, 1'b0};
  assign addr_inc      = addr_q + AW'(1);
  assign addr_page_inc = {addr_q[AW-1:PAGE_AW], addr_q[PAGE_AW-1:0] + PAGE_AW'(1)};

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= 3'b000;
      csn_q  <= 2'b11;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      csn_q  <= {csn_q[0], csn};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      tx_q      <= 8'd0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      wel_q     <= 1'b0;
      wen_op_q  <= WOP_NONE;
      extra_q   <= 1'b0;
      wrote_q   <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_data_q <= 8'd0;
      for (int i = 0; i < (1 << AW); i++) begin
        mem_q[i] <= 8'hFF;
      end
    end else begin
      // A completed byte commits one clk after its last bit, even if csn is already high.
      wr_pend_q <= 1'b0;
      if (wr_pend_q) begin
        mem_q[addr_q] <= wr_data_q;
        addr_q        <= addr_page_inc;
      end

      if (csn_s) begin
        if (state_q == IGNORE && !extra_q) begin
          case (wen_op_q)
            WOP_SET:   wel_q <= 1'b1;
            WOP_CLEAR: wel_q <= 1'b0;
            default:   wel_q <= wel_q;
          endcase
        end
        if (state_q == WR_DATA && wrote_q) begin
          wel_q <= 1'b0;
        end
        state_q   <= IDLE;
        bit_cnt_q <= 3'd0;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= CMD;
            bit_cnt_q <= 3'd0;
            extra_q   <= 1'b0;
            wrote_q   <= 1'b0;
            wen_op_q  <= WOP_NONE;
          end
          CMD: begin
            if (sck_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (last_bit) begin
                case (rx_byte)
                  8'h06: begin
                    state_q  <= IGNORE;
                    wen_op_q <= WOP_SET;
                  end
                  8'h04: begin
                    state_q  <= IGNORE;
                    wen_op_q <= WOP_CLEAR;
                  end
                  8'h05: begin
                    state_q   <= STATUS;
                    tx_q      <= status_byte;
                    miso_oe_q <= 1'b1;
                  end
                  8'h03: begin
                    state_q <= ADDR;
                    rd_q    <= 1'b1;
                  end
                  8'h02: begin
                    state_q <= wel_q ? ADDR : IGNORE;
                    rd_q    <= 1'b0;
                  end
                  default: state_q <= IGNORE;
                endcase
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (last_bit) begin
                addr_q <= rx_byte[AW-1:0];
                if (rd_q) begin
                  state_q   <= RD_DATA;
                  tx_q      <= mem_q[rx_byte[AW-1:0]];
                  miso_oe_q <= 1'b1;
                end else begin
                  state_q <= WR_DATA;
                end
              end
            end
          end
          RD_DATA, STATUS: begin
            if (sck_fall) begin
              miso_q    <= tx_q[7];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (!last_bit) begin
                tx_q <= {tx_q[6:0], 1'b0};
              end else if (state_q == RD_DATA) begin
                addr_q <= addr_inc;
                tx_q   <= mem_q[addr_inc];
              end else begin
                tx_q <= status_byte;
              end
            end
          end
          WR_DATA: begin
            if (sck_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (last_bit) begin
                wr_pend_q <= 1'b1;
                wr_data_q <= rx_byte;
                wrote_q   <= 1'b1;
              end
            end
          end
          IGNORE: begin
            if (sck_rise) begin
              extra_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign miso    = miso_q;
  assign miso_oe = miso_oe_q;
  assign wel     = wel_q;

endmodule

// File: tb/tb_spi_eeprom_slave.sv
`timescale 1ns/1ps
// Randomised bench for spi_eeprom_slave: an SPI master drives transactions, a reference
// EEPROM model predicts read/status bytes into a queue, and a monitor checks miso bytes.
module tb_spi_eeprom_slave;

  localparam int HALF = 60;

  logic clk = 1'b0;
  logic rst;
  logic sck;
  logic csn;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic wel;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] ref_mem [128];
  logic       ref_wel;
  logic [7:0] exp_q [$];

  spi_eeprom_slave #(.AW(7), .PAGE_AW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .csn     (csn),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .wel     (wel)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  // Monitor: assembles miso bits sampled on sck rise while the DUT drives them.
  initial begin : mon
    logic [7:0] sh;
    logic [7:0] e;
    int         cnt;
    sh  = 8'h00;
    cnt = 0;
    forever begin
      @(posedge sck or posedge csn);
      if (csn === 1'b1) begin
        cnt = 0;
      end else if (miso_oe === 1'b1) begin
        sh = {sh[6:0], miso};
        cnt++;
        if (cnt == 8) begin
          cnt = 0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h want none", sh);
          end else begin
            e = exp_q.pop_front();
            check("miso_byte", {24'd0, sh}, {24'd0, e});
          end
        end
      end
    end
  end

  // Shift the top nbits of b out MSB first; oe_exp 0/1 checks miso_oe at every rise, 2 skips.
  task automatic xfer(input logic [7:0] b, input int nbits, input int oe_exp);
    logic seen0;
    logic seen1;
    seen0 = 1'b0;
    seen1 = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      #(HALF);
      if (miso_oe === 1'b1) seen1 = 1'b1;
      else                  seen0 = 1'b1;
      sck = 1'b1;
      #(HALF);
      sck = 1'b0;
    end
    if (oe_exp == 0) check("oe_low", {31'd0, seen1}, 32'd0);
    else if (oe_exp == 1) check("oe_high", {31'd0, seen0}, 32'd0);
  endtask

  task automatic begin_tx();
    csn = 1'b0;
    #(HALF);
  endtask

  task automatic end_tx();
    #(HALF);
    csn = 1'b1;
    #(HALF * 2);
    check("oe_idle", {31'd0, miso_oe}, 32'd0);
    check("miso_idle", {31'd0, miso}, 32'd0);
    check("wel", {31'd0, wel}, {31'd0, ref_wel});
  endtask

  task automatic op_wen(input logic set, input int extra);
    begin_tx();
    xfer(set ? 8'h06 : 8'h04, 8, 0);
    if (extra > 0) xfer(8'($urandom()), extra, 2);
    if (extra == 0) ref_wel = set;
    end_tx();
  endtask

  task automatic op_rdsr(input int n);
    begin_tx();
    xfer(8'h05, 8, 0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({6'd0, ref_wel, 1'b0});
      xfer(8'($urandom()), 8, 1);
    end
    end_tx();
  endtask

  task automatic op_read(input int addr, input int n);
    logic [7:0] ab;
    ab = {1'($urandom()), 7'(addr)};
    begin_tx();
    xfer(8'h03, 8, 0);
    xfer(ab, 8, 0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ref_mem[(addr + i) % 128]);
      xfer(8'($urandom()), 8, 1);
    end
    end_tx();
  endtask

  // Byte i of the write burst is d[31-8*i -: 8]; a partial trailing byte has pbits bits.
  task automatic op_write(input int addr, input logic [31:0] d, input int nfull, input int pbits);
    logic [7:0] ab;
    ab = {1'($urandom()), 7'(addr)};
    begin_tx();
    xfer(8'h02, 8, 0);
    xfer(ab, 8, 0);
    for (int i = 0; i < nfull; i++) xfer(d[31-8*i -: 8], 8, 0);
    if (pbits > 0) xfer(8'($urandom()), pbits, 0);
    if (ref_wel) begin
      for (int i = 0; i < nfull; i++) ref_mem[(addr / 16) * 16 + ((addr % 16) + i) % 16] = d[31-8*i -: 8];
      if (nfull > 0) ref_wel = 1'b0;
    end
    end_tx();
  endtask

  initial begin
    int sel;
    int ext;
    rst  = 1'b1;
    csn  = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    ref_wel = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'hFF;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_wel", {31'd0, wel}, 32'd0);

    op_rdsr(2);
    op_wen(1'b1, 0);
    op_rdsr(1);
    op_wen(1'b0, 0);
    op_write(8'h10, 32'h55000000, 1, 0);
    op_read(8'h10, 1);
    op_wen(1'b1, 0);
    op_write(8'h0E, 32'hA55AC300, 3, 0);
    op_read(8'h0E, 2);
    op_read(8'h7F, 2);
    op_wen(1'b1, 0);
    op_write(8'h20, 32'h11000000, 1, 4);
    op_read(8'h20, 2);
    op_wen(1'b1, 3);
    op_wen(1'b1, 0);
    op_wen(1'b0, 1);

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 5);
      ext = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      case (sel)
        0: op_wen(1'b1, ext);
        1: op_wen(1'b0, ext);
        2: op_rdsr($urandom_range(1, 3));
        3: op_read($urandom_range(0, 127), $urandom_range(1, 4));
        default: begin
          if (sel == 4) op_wen(1'b1, 0);
          op_write($urandom_range(0, 127), $urandom(), $urandom_range(0, 4), $urandom_range(0, 7));
        end
      endcase
    end

    op_read(0, 128);
    #(HALF * 4);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
